haze_pass_sequencer: RTL and testbench
======================================

# haze_pass_sequencer

Two-pass frame sequencer in front of the haze-removal datapath. Accepts one AXI4-Stream frame per pass from the DMA and routes pass 1 to atmospheric light estimation (ALE). It then waits for `ale_done`, routes pass 2 of the same frame to transmission estimation / SRSC (TE), and generates `M_AXIS_TLAST` on the datapath output. It replaces testbench-driven pass sequencing so that DMA and software only stream the frame twice.

## Interface
- `IMG_WIDTH`, default 512: pixels per line.
- `IMG_HEIGHT`, default 512: lines per frame.
- `FRAME_PIXELS`, default `IMG_WIDTH*IMG_HEIGHT`: beats per pass. Counter width is `CW = $clog2(FRAME_PIXELS+1)`.
- `ACLK`  in  1  clock.
- `ARESETn`  in  1  reset, synchronous, active-low; clock ACLK.
- `enable`  in  1  frame start permission, sampled only in IDLE.
- `S_AXIS_TDATA`  in  32  pixel {8'h0,R,G,B}. `S_AXIS_TVALID` in 1. `S_AXIS_TLAST` in 1. `S_AXIS_TREADY` out 1.
- `ale_tdata`  out  24. `ale_tvalid` out 1. `ale_tready` in 1: ALE input.
- `ale_clear`  out  1  one-cycle pulse resetting ALE accumulators.
- `ale_done`  in  1  ALE result valid (pulse or level).
- `te_tdata`  out  24. `te_tvalid` out 1. `te_tready` in 1: TE/SRSC input.
- `dp_tdata`  in  24. `dp_tvalid` in 1. `dp_tready` out 1: datapath output.
- `M_AXIS_TDATA`  out  32 `{8'h0,dp_tdata}`. `M_AXIS_TVALID` out 1. `M_AXIS_TLAST` out 1. `M_AXIS_TREADY` in 1.
- `busy`  out  1  state != IDLE.
- `pass_id`  out  2  0 idle, 1 pass 1, 2 pass 2/drain.
- `frame_done`  out  1  one-cycle pulse after the last output beat.
- `err_tlast`  out  1  sticky; cleared by `ale_clear`.
- `err_stray`  out  1  sticky; cleared by `ale_clear`.

## Operation
- States:
  - IDLE→PASS1 when `enable`=1. `ale_clear` pulses on that transition; `in_cnt`, `out_cnt`, `ale_seen` and the error flags clear.
  - PASS1: `S_AXIS_TREADY=ale_tready`, `ale_tvalid=S_AXIS_TVALID`, `ale_tdata=S_AXIS_TDATA[23:0]`. On the accepted beat with `in_cnt==FRAME_PIXELS-1`, go to WAIT_ALE and set `in_cnt=0`.
  - WAIT_ALE: `S_AXIS_TREADY=0`. Go to PASS2 when `ale_seen`=1. `ale_seen` is set by `ale_done` in PASS1 or WAIT_ALE, so an early `ale_done` is not lost.
  - PASS2: same routing as PASS1, to the `te_*` signals. The last accepted beat goes to DRAIN.
  - DRAIN: no input is accepted. Output counting continues.
  - Leave PASS2 or DRAIN to IDLE on the accepted output beat with `out_cnt==FRAME_PIXELS-1`; `frame_done` pulses. If that beat lands in PASS2 (it cannot normally), still go to IDLE, and set `err_stray`.
- Output side:
  - In PASS2/DRAIN: `M_AXIS_TVALID=dp_tvalid`, `dp_tready=M_AXIS_TREADY`, and `M_AXIS_TLAST=(out_cnt==FRAME_PIXELS-1)&M_AXIS_TVALID`.
  - In other states: `M_AXIS_TVALID=0`, `dp_tready=1` so stray beats are discarded, and each stray beat sets `err_stray`.
- TLAST check (input): `err_tlast` sets when `S_AXIS_TLAST`=1 on a non-final beat, or `S_AXIS_TLAST`=0 on the final beat of either pass. Pass termination is count-based only; TLAST never shortens or extends a pass.
- `enable` is ignored outside IDLE. Deasserting it mid-frame does not abort the frame.
- Counters increment only on valid&ready handshakes and never wrap past `FRAME_PIXELS-1`.
- Reset mid-frame: return to IDLE immediately. `ale_clear` is not pulsed; the next frame start pulses it.

## Timing
- Reset values:
  - State IDLE; `in_cnt`, `out_cnt` and `ale_seen` are 0.
  - All outputs are 0 except `dp_tready`=1 and `pass_id`=0.
- Forwarding has zero latency (combinational): TREADY/TVALID/TDATA pass straight through. There is one combinational ready path S←ale/te and one dp←M.
- `ale_clear` is registered and asserted in the first PASS1 cycle. Input is accepted in that same cycle.
- WAIT_ALE→PASS2 takes 1 cycle after `ale_seen`. With `ale_done` already seen in PASS1, WAIT_ALE lasts exactly 1 cycle.
- `frame_done` is registered: it is high in the cycle after the final M handshake, when state=IDLE. A new frame can start in that same cycle if `enable`=1.
- Simultaneous input-final and output-final handshakes in PASS2 go directly to IDLE.

## Structure
- Package `haze_pkg`:
  - State enum `seq_state_t` (IDLE, PASS1, WAIT_ALE, PASS2, DRAIN).
  - Pass codes `PASS_IDLE/1/2`.
  - Default image size constants.
- Sub-module `haze_beat_counter` (parameter `MAX`; inputs `clear`, `inc`; outputs `count`, `is_last`). It is instantiated twice, for input and output.

## Test plan
- Frame size 4×4 (16 beats), backpressure free, `ale_done` 3 cycles after pass 1 → 16 beats on `ale_*`, then 16 on `te_*`. `M_AXIS_TLAST` is on the 16th output beat only; `frame_done` pulses once; no errors.
- Random `ale_tready`/`te_tready`/`M_AXIS_TREADY` at 50% → all 32 input beats are transferred in order and 16 outputs are counted; no beat is dropped or duplicated.
- `ale_done` pulsed on pass-1 beat 10 → WAIT_ALE lasts 1 cycle; pass 2 proceeds.
- TLAST on beat 8, or missing on beat 16 → `err_tlast`=1; the pass still ends at beat 16.
- `dp_tvalid` in IDLE → `dp_tready`=1, `M_AXIS_TVALID`=0, `err_stray`=1. The next frame start clears it.
- `ARESETn`=0 during PASS2 beat 5 → IDLE next cycle, all outputs at reset values. The next frame runs cleanly with `ale_clear` pulsed.

Source files
------------

// File: rtl/haze_pass_sequencer_pkg.sv
// Shared types and constants for the two-pass haze frame sequencer.
package haze_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS1    = 3'd1,
        WAIT_ALE = 3'd2,
        PASS2    = 3'd3,
        DRAIN    = 3'd4
    } seq_state_t;

    localparam logic [1:0] PASS_IDLE = 2'd0;
    localparam logic [1:0] PASS_1    = 2'd1;
    localparam logic [1:0] PASS_2    = 2'd2;

    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;

endpackage

// File: rtl/haze_pass_sequencer_if.sv
// Stream bundle around the sequencer: DMA input, ALE and TE feeds,
// datapath return and the M_AXIS output. The sequencer uses the slave view.
interface haze_pass_sequencer_if;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;

    logic [23:0] ale_tdata;
    logic        ale_tvalid;
    logic        ale_tready;

    logic [23:0] te_tdata;
    logic        te_tvalid;
    logic        te_tready;

    logic [23:0] dp_tdata;
    logic        dp_tvalid;
    logic        dp_tready;

    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output ale_tdata, ale_tvalid,
        input  ale_tready,
        output te_tdata, te_tvalid,
        input  te_tready,
        input  dp_tdata, dp_tvalid,
        output dp_tready,
        output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  ale_tdata, ale_tvalid,
        output ale_tready,
        input  te_tdata, te_tvalid,
        output te_tready,
        output dp_tdata, dp_tvalid,
        input  dp_tready,
        input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/haze_pass_sequencer_counter.sv
// Beat counter: counts handshakes 0..MAX-1 and returns to 0 after the last one.
module haze_beat_counter
    import haze_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       i_clear,
    input  logic                       i_inc,
    output logic [$clog2(MAX+1)-1:0]   o_count,
    output logic                       o_is_last
);
    localparam int CW = $clog2(MAX+1);

    logic [CW-1:0] r_count;

    // Count accepted beats; the last beat of a pass folds the count back to 0.
    always_ff @(posedge ACLK) begin
        if (!ARESETn || i_clear)
            r_count <= '0;
        else if (i_inc)
            r_count <= o_is_last ? '0 : r_count + 1'b1;
    end

    assign o_count   = r_count;
    assign o_is_last = (r_count == CW'(MAX - 1));
endmodule

// File: rtl/haze_pass_sequencer.sv
// Two-pass frame sequencer: pass 1 feeds ALE, pass 2 feeds TE once ALE has
// reported, and the datapath return is framed with a count-based TLAST.
//
// state    | meaning
// IDLE     | waiting for enable; stray datapath beats are discarded
// PASS1    | input stream routed to ALE
// WAIT_ALE | input stalled until ale_done has been seen
// PASS2    | input stream routed to TE, datapath output forwarded
// DRAIN    | input complete, forwarding remaining datapath output
module haze_pass_sequencer
    import haze_pkg::*;
#(
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
    parameter int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   i_enable,
    haze_pass_sequencer_if.slave   bus,
    output logic                   o_ale_clear,
    input  logic                   i_ale_done,
    output logic                   o_busy,
    output logic [1:0]             o_pass_id,
    output logic                   o_frame_done,
    output logic                   o_err_tlast,
    output logic                   o_err_stray
);
    localparam int CW = $clog2(FRAME_PIXELS + 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic          r_ale_seen;
    logic          r_ale_clear;
    logic          r_frame_done;
    logic          r_err_tlast;
    logic          r_err_stray;

    logic [CW-1:0] w_in_cnt;
    logic [CW-1:0] w_out_cnt;
    logic          w_in_last;
    logic          w_out_last;
    logic          w_start;
    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_out_pass;
    logic          w_in_fin;
    logic          w_out_fin;
    logic          w_unused_tdata_hi;

    assign w_start    = (r_state == IDLE) && i_enable;
    assign w_in_hs    = bus.S_AXIS_TVALID && bus.S_AXIS_TREADY;
    assign w_out_hs   = bus.dp_tvalid && bus.dp_tready;
    assign w_out_pass = (r_state == PASS2) || (r_state == DRAIN);
    assign w_in_fin   = w_in_hs && w_in_last;
    assign w_out_fin  = w_out_hs && w_out_pass && w_out_last;

    assign w_unused_tdata_hi = ^bus.S_AXIS_TDATA[31:24];

    haze_beat_counter #(.MAX(FRAME_PIXELS)) u_in_cnt (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .i_clear   (w_start),
        .i_inc     (w_in_hs),
        .o_count   (w_in_cnt),
        .o_is_last (w_in_last)
    );

    haze_beat_counter #(.MAX(FRAME_PIXELS)) u_out_cnt (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .i_clear   (w_start),
        .i_inc     (w_out_hs && w_out_pass),
        .o_count   (w_out_cnt),
        .o_is_last (w_out_last)
    );

    // State register; reset drops straight back to IDLE without an ALE clear.
    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: passes end on beat count; the output-final beat always wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_enable)   w_next = PASS1;
            PASS1:    if (w_in_fin)   w_next = WAIT_ALE;
            WAIT_ALE: if (r_ale_seen) w_next = PASS2;
            PASS2: begin
                if (w_out_fin)       w_next = IDLE;
                else if (w_in_fin)   w_next = DRAIN;
            end
            DRAIN:    if (w_out_fin)  w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // Outputs: zero-latency routing of the input and datapath streams by state.
    always_comb begin
        bus.S_AXIS_TREADY = 1'b0;
        bus.ale_tdata     = '0;
        bus.ale_tvalid    = 1'b0;
        bus.te_tdata      = '0;
        bus.te_tvalid     = 1'b0;
        bus.dp_tready     = 1'b1;
        bus.M_AXIS_TDATA  = '0;
        bus.M_AXIS_TVALID = 1'b0;
        bus.M_AXIS_TLAST  = 1'b0;
        o_busy            = (r_state != IDLE);
        o_pass_id         = PASS_IDLE;
        case (r_state)
            PASS1, WAIT_ALE: o_pass_id = PASS_1;
            PASS2, DRAIN:    o_pass_id = PASS_2;
            default:         o_pass_id = PASS_IDLE;
        endcase
        if (r_state == PASS1) begin
            bus.S_AXIS_TREADY = bus.ale_tready;
            bus.ale_tvalid    = bus.S_AXIS_TVALID;
            bus.ale_tdata     = bus.S_AXIS_TDATA[23:0];
        end
        if (r_state == PASS2) begin
            bus.S_AXIS_TREADY = bus.te_tready;
            bus.te_tvalid     = bus.S_AXIS_TVALID;
            bus.te_tdata      = bus.S_AXIS_TDATA[23:0];
        end
        if (w_out_pass) begin
            bus.M_AXIS_TVALID = bus.dp_tvalid;
            bus.M_AXIS_TDATA  = {8'h00, bus.dp_tdata};
            bus.M_AXIS_TLAST  = w_out_last && bus.dp_tvalid;
            bus.dp_tready     = bus.M_AXIS_TREADY;
        end
    end

    // Status flags: frame start clears them, the ALE clear and frame_done are pulses.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_ale_seen   <= 1'b0;
            r_ale_clear  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_tlast  <= 1'b0;
            r_err_stray  <= 1'b0;
        end else begin
            r_ale_clear  <= w_start;
            r_frame_done <= w_out_fin;
            if (w_start) begin
                r_ale_seen  <= 1'b0;
                r_err_tlast <= 1'b0;
                r_err_stray <= 1'b0;
            end else begin
                if (i_ale_done && ((r_state == PASS1) || (r_state == WAIT_ALE)))
                    r_ale_seen <= 1'b1;
                if (w_in_hs && (bus.S_AXIS_TLAST != w_in_last))
                    r_err_tlast <= 1'b1;
                // A stray beat outside the output window, or the output frame
                // completing before pass 2 input has finished.
                if ((w_out_hs && !w_out_pass) ||
                    (w_out_fin && (r_state == PASS2) && !w_in_fin))
                    r_err_stray <= 1'b1;
            end
        end
    end

    assign o_ale_clear  = r_ale_clear;
    assign o_frame_done = r_frame_done;
    assign o_err_tlast  = r_err_tlast;
    assign o_err_stray  = r_err_stray;
endmodule

// File: tb/tb_haze_pass_sequencer.sv
// Scoreboard bench for the two-pass sequencer on a 4x4 frame.
module tb_haze_pass_sequencer;
    import haze_pkg::*;

    localparam int N = 16;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       enable = 1'b0;
    logic       ale_done = 1'b0;
    logic       ale_clear, busy, frame_done, err_tlast, err_stray;
    logic [1:0] pass_id;

    haze_pass_sequencer_if bus();

    haze_pass_sequencer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .i_enable     (enable),
        .bus          (bus),
        .o_ale_clear  (ale_clear),
        .i_ale_done   (ale_done),
        .o_busy       (busy),
        .o_pass_id    (pass_id),
        .o_frame_done (frame_done),
        .o_err_tlast  (err_tlast),
        .o_err_stray  (err_stray)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fails  = 0;

    logic [23:0] exp_ale[$];
    logic [23:0] exp_te[$];
    logic [24:0] exp_m[$];
    logic [23:0] dp_fifo[$];

    bit rand_mode = 0;
    bit dp_force  = 0;
    bit dp_flush  = 0;
    int fd_cnt = 0, clr_cnt = 0, wait_cnt = 0, m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] f_dp(input logic [23:0] p);
        return p ^ 24'hA5C3F0;
    endfunction

    // Sink readiness: all-ready or random 50%.
    initial begin
        bus.ale_tready = 1'b1; bus.te_tready = 1'b1; bus.M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            if (rand_mode) begin
                bus.ale_tready    = 1'($urandom_range(0, 1));
                bus.te_tready     = 1'($urandom_range(0, 1));
                bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
            end else begin
                bus.ale_tready = 1'b1; bus.te_tready = 1'b1; bus.M_AXIS_TREADY = 1'b1;
            end
        end
    end

    // Behavioural datapath: TE beats come back transformed, one cycle or more later.
    initial begin
        logic        hs_dp, hs_te, drove_fifo;
        logic [23:0] te_d;
        drove_fifo = 1'b0;
        bus.dp_tvalid = 1'b0; bus.dp_tdata = '0;
        forever begin
            @(negedge ACLK);
            hs_dp = bus.dp_tvalid && bus.dp_tready && drove_fifo;
            hs_te = bus.te_tvalid && bus.te_tready;
            te_d  = bus.te_tdata;
            @(posedge ACLK); #1;
            if (dp_flush) dp_fifo.delete();
            else begin
                if (hs_dp && dp_fifo.size() > 0) void'(dp_fifo.pop_front());
                if (hs_te) dp_fifo.push_back(f_dp(te_d));
            end
            drove_fifo = 1'b0;
            if (dp_force) begin
                bus.dp_tvalid = 1'b1; bus.dp_tdata = 24'h123456;
            end else if (dp_fifo.size() > 0) begin
                bus.dp_tvalid = 1'b1; bus.dp_tdata = dp_fifo[0]; drove_fifo = 1'b1;
            end else begin
                bus.dp_tvalid = 1'b0; bus.dp_tdata = '0;
            end
        end
    end

    // Monitor: pops expected beats on every DUT handshake.
    initial begin
        logic prev_m_last;
        logic [24:0] e;
        prev_m_last = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARESETn) begin
                if (bus.ale_tvalid && bus.ale_tready) begin
                    if (exp_ale.size() == 0) chk("ale_extra_beat", 1, 0);
                    else chk("ale_data", bus.ale_tdata, exp_ale.pop_front());
                end
                if (bus.te_tvalid && bus.te_tready) begin
                    if (exp_te.size() == 0) chk("te_extra_beat", 1, 0);
                    else chk("te_data", bus.te_tdata, exp_te.pop_front());
                end
                if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
                    m_cnt++;
                    if (exp_m.size() == 0) chk("m_extra_beat", 1, 0);
                    else begin
                        e = exp_m.pop_front();
                        chk("m_data", bus.M_AXIS_TDATA, {8'h00, e[23:0]});
                        chk("m_tlast", bus.M_AXIS_TLAST, e[24]);
                    end
                end
                if (ale_clear) begin
                    clr_cnt++;
                    chk("clear_in_pass1", pass_id, PASS_1);
                    chk("clear_errs_cleared", {err_tlast, err_stray}, 2'b00);
                end
                if (frame_done) begin
                    fd_cnt++;
                    chk("fd_after_last_beat", prev_m_last, 1);
                    chk("fd_in_idle", busy, 0);
                end
                if (busy && pass_id == PASS_1 && !bus.S_AXIS_TREADY) wait_cnt++;
            end
            prev_m_last = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && bus.M_AXIS_TLAST;
        end
    end

    // Drive one pass of N beats; tl_mode 1 = early TLAST on beat 8, 2 = missing on beat 16.
    task automatic send_pass(input int pass, input logic [23:0] base, input int tl_mode,
                             input int done_beat, input int rst_beat);
        int t;
        logic [23:0] px;
        for (int i = 0; i < N; i++) begin
            px = base + 24'(i * 3);
            if (i == rst_beat) begin
                bus.S_AXIS_TVALID = 1'b0;
                dp_flush = 1'b1;
                ARESETn  = 1'b0;
                return;
            end
            bus.S_AXIS_TDATA  = {8'h00, px};
            bus.S_AXIS_TVALID = 1'b1;
            bus.S_AXIS_TLAST  = (i == N-1);
            if (tl_mode == 1 && i == 7)   bus.S_AXIS_TLAST = 1'b1;
            if (tl_mode == 2 && i == N-1) bus.S_AXIS_TLAST = 1'b0;
            if (i == done_beat) ale_done = 1'b1;
            if (pass == 1) exp_ale.push_back(px);
            else begin
                exp_te.push_back(px);
                exp_m.push_back({(i == N-1), f_dp(px)});
            end
            t = 0;
            do begin @(negedge ACLK); t++; end while (!bus.S_AXIS_TREADY && t < 300);
            if (!bus.S_AXIS_TREADY) begin
                chk("s_ready_timeout", 0, 1);
                bus.S_AXIS_TVALID = 1'b0;
                return;
            end
            @(posedge ACLK); #1;
            ale_done = 1'b0;
        end
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic start_frame();
        wait_cnt = 0;
        enable = 1'b1;
        @(posedge ACLK); #1;
        enable = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int clr0, input int fd0, input int m0,
                                input logic exp_tlast_err);
        int t;
        t = 0;
        while (fd_cnt == fd0 && t < 1000) begin @(negedge ACLK); t++; end
        chk({tag, "_frame_done_seen"}, (fd_cnt != fd0), 1);
        repeat (2) @(negedge ACLK);
        chk({tag, "_frame_done_once"}, fd_cnt - fd0, 1);
        chk({tag, "_ale_clear_once"}, clr_cnt - clr0, 1);
        chk({tag, "_out_beats"}, m_cnt - m0, N);
        chk({tag, "_queues_empty"}, exp_ale.size() + exp_te.size() + exp_m.size(), 0);
        chk({tag, "_err_tlast"}, err_tlast, exp_tlast_err);
        chk({tag, "_err_stray"}, err_stray, 0);
        chk({tag, "_idle"}, {busy, pass_id}, 3'b000);
        @(posedge ACLK); #1;
    endtask

    task automatic run_frame(input string tag, input logic [23:0] base, input int tl1,
                             input int tl2, input int done_beat, input logic exp_tlast_err);
        int clr0, fd0, m0;
        clr0 = clr_cnt; fd0 = fd_cnt; m0 = m_cnt;
        start_frame();
        send_pass(1, base, tl1, done_beat, -1);
        if (done_beat < 0) begin
            repeat (3) @(posedge ACLK); #1;
            ale_done = 1'b1;
            @(posedge ACLK); #1;
            ale_done = 1'b0;
        end
        send_pass(2, base, tl2, -1, -1);
        finish_frame(tag, clr0, fd0, m0, exp_tlast_err);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass_id"}, pass_id, PASS_IDLE);
        chk({tag, "_ale_clear"}, ale_clear, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_errs"}, {err_tlast, err_stray}, 2'b00);
        chk({tag, "_s_tready"}, bus.S_AXIS_TREADY, 0);
        chk({tag, "_dp_tready"}, bus.dp_tready, 1);
        chk({tag, "_m_valid_last"}, {bus.M_AXIS_TVALID, bus.M_AXIS_TLAST}, 2'b00);
        chk({tag, "_fwd_valids"}, {bus.ale_tvalid, bus.te_tvalid}, 2'b00);
    endtask

    initial begin
        #200us;
        n_fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        bus.S_AXIS_TDATA = '0; bus.S_AXIS_TVALID = 1'b0; bus.S_AXIS_TLAST = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_reset_values("reset");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Basic frame, ale_done 3 cycles after pass 1.
        run_frame("basic", 24'h100000, 0, 0, -1, 1'b0);
        chk("basic_wait_ale_cycles", wait_cnt, 5);

        // Random backpressure on all three sinks.
        rand_mode = 1;
        run_frame("random", 24'h200010, 0, 0, -1, 1'b0);
        rand_mode = 0;
        @(posedge ACLK); #1;

        // Early ale_done on pass-1 beat 10.
        run_frame("early_done", 24'h300020, 0, 0, 9, 1'b0);
        chk("early_done_wait_ale_cycles", wait_cnt, 1);

        // TLAST protocol errors; passes still end on count.
        run_frame("tlast_early", 24'h400030, 1, 0, -1, 1'b1);
        run_frame("tlast_missing", 24'h500040, 0, 2, -1, 1'b1);

        // Stray datapath beat in IDLE.
        dp_force = 1'b1;
        @(posedge ACLK); #2;
        @(negedge ACLK);
        chk("stray_dp_tready", bus.dp_tready, 1);
        chk("stray_m_valid", bus.M_AXIS_TVALID, 0);
        dp_force = 1'b0;
        @(negedge ACLK);
        chk("stray_err_set", err_stray, 1);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        run_frame("after_stray", 24'h600050, 0, 0, -1, 1'b0);

        // Reset during pass-2 beat 5.
        start_frame();
        send_pass(1, 24'h700060, 0, 2, -1);
        send_pass(2, 24'h700060, 0, -1, 4);
        @(posedge ACLK);
        @(negedge ACLK);
        check_reset_values("midreset");
        @(posedge ACLK); #1;
        ARESETn  = 1'b1;
        dp_flush = 1'b0;
        exp_ale.delete(); exp_te.delete(); exp_m.delete();
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("midreset_no_clear", ale_clear, 0);
        @(posedge ACLK); #1;
        run_frame("after_reset", 24'h800070, 0, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
